// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: 32-bit loads/stores on a 16-bit SRAM,
// done as a low half-word phase followed by a high half-word phase.
// ready drops for the duration of an access so the pipeline freezes.
module mem_stage_sram_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  output logic [31:0]        mem_read_value,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int unsigned      CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WAIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_WR_LO = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [SRAM_AW-2:0] word_q;   // SRAM word (32-bit) index latched at access start
  logic [31:0]        wdata_q;  // store data latched at access start
  logic [31:0]        off;
  logic               phase_last;
  logic               is_wr;
  logic               is_hi;
  logic               unused_off_bits;

  assign off             = alu_result - BASE_ADDR;
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};
  assign phase_last      = (cnt == CNT_LAST);

  // Access sequencer: phase counter, state advance, address/data latch, load capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      word_q         <= '0;
      wdata_q        <= '0;
      mem_read_value <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (mem_w_en) begin
            state   <= S_WR_LO;
            word_q  <= off[SRAM_AW:2];
            wdata_q <= val_rm;
          end else if (mem_r_en) begin
            state  <= S_RD_LO;
            word_q <= off[SRAM_AW:2];
          end
        end
        S_RD_LO: begin
          if (phase_last) begin
            cnt                   <= '0;
            state                 <= S_RD_HI;
            mem_read_value[15:0]  <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RD_HI: begin
          if (phase_last) begin
            cnt                   <= '0;
            state                 <= S_DONE;
            mem_read_value[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WR_LO: begin
          if (phase_last) begin
            cnt   <= '0;
            state <= S_WR_HI;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WR_HI: begin
          if (phase_last) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // The request is still held here; returning to IDLE unconditionally
        // keeps it from restarting the access the pipeline is retiring.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // SRAM pins and handshake decoded from the registered state
  always_comb begin
    is_wr       = (state == S_WR_LO) || (state == S_WR_HI);
    is_hi       = (state == S_RD_HI) || (state == S_WR_HI);
    sram_we_n   = ~is_wr;
    sram_dq_oe  = is_wr;
    sram_addr   = {word_q, is_hi};
    sram_dq_out = '0;
    if (state == S_WR_LO) sram_dq_out = wdata_q[15:0];
    if (state == S_WR_HI) sram_dq_out = wdata_q[31:16];
    ready = ((state == S_IDLE) && !mem_r_en && !mem_w_en) || (state == S_DONE);
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=1 instance, each attached to a small behavioural SRAM.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: WAIT_CYCLES = 2
  logic        r_en0 = 1'b0, w_en0 = 1'b0;
  logic [31:0] alu0 = '0, val0 = '0, mrv0;
  logic        ready0, oe0, we_n0;
  logic [17:0] addr0;
  logic [15:0] dq_out0, dq_in0;
  logic [15:0] sram_mem0 [0:63];

  // instance 1: WAIT_CYCLES = 1
  logic        r_en1 = 1'b0, w_en1 = 1'b0;
  logic [31:0] alu1 = '0, val1 = '0, mrv1;
  logic        ready1, oe1, we_n1;
  logic [17:0] addr1;
  logic [15:0] dq_out1, dq_in1;
  logic [15:0] sram_mem1 [0:63];

  int unsigned checks = 0;
  int unsigned failures = 0;

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en0), .mem_w_en(w_en0),
    .alu_result(alu0), .val_rm(val0), .mem_read_value(mrv0), .ready(ready0),
    .sram_addr(addr0), .sram_dq_out(dq_out0), .sram_dq_in(dq_in0),
    .sram_dq_oe(oe0), .sram_we_n(we_n0));

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en1), .mem_w_en(w_en1),
    .alu_result(alu1), .val_rm(val1), .mem_read_value(mrv1), .ready(ready1),
    .sram_addr(addr1), .sram_dq_out(dq_out1), .sram_dq_in(dq_in1),
    .sram_dq_oe(oe1), .sram_we_n(we_n1));

  // behavioural SRAMs: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (!we_n0 && oe0) sram_mem0[addr0[5:0]] <= dq_out0;
    if (!we_n1 && oe1) sram_mem1[addr1[5:0]] <= dq_out1;
  end
  assign dq_in0 = sram_mem0[addr0[5:0]];
  assign dq_in1 = sram_mem1[addr1[5:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready0 !== 1'b1 || we_n0 !== 1'b1 || oe0 !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_ctl cyc=%0d ready/we_n/oe got %b%b%b want 110", i, ready0, we_n0, oe0);
      end
      checks++;
      if (mrv0 !== 32'h0 || addr0 !== 18'h0 || dq_out0 !== 16'h0) begin
        failures++;
        $display("FAIL reset_idle_data cyc=%0d mrv=%h addr=%h dq=%h want 0", i, mrv0, addr0, dq_out0);
      end
      checks++;
      if (ready1 !== 1'b1 || we_n1 !== 1'b1 || oe1 !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle_w1 cyc=%0d ready/we_n/oe got %b%b%b want 110", i, ready1, we_n1, oe1);
      end
      tick();
    end
  endtask

  task automatic test_store();
    logic        exp_ready, exp_we_n;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    w_en0 = 1'b1; alu0 = 32'd1032; val0 = 32'hDEADBEEF;
    #1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) tick();
      exp_ready = (i == 5);
      exp_we_n  = !(i >= 1 && i <= 4);
      exp_addr  = (i <= 2) ? 18'd4 : 18'd5;
      exp_dq    = (i <= 2) ? 16'hBEEF : 16'hDEAD;
      checks++;
      if (ready0 !== exp_ready) begin
        failures++;
        $display("FAIL store_ready cyc=%0d got %b want %b", i, ready0, exp_ready);
      end
      checks++;
      if (we_n0 !== exp_we_n || oe0 !== !exp_we_n) begin
        failures++;
        $display("FAIL store_we cyc=%0d we_n=%b oe=%b want we_n=%b", i, we_n0, oe0, exp_we_n);
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if (addr0 !== exp_addr || dq_out0 !== exp_dq) begin
          failures++;
          $display("FAIL store_bus cyc=%0d addr=%0d dq=%h want addr=%0d dq=%h", i, addr0, dq_out0, exp_addr, exp_dq);
        end
      end
    end
    tick();
    w_en0 = 1'b0;
    #1;
    checks++;
    if (ready0 !== 1'b1 || we_n0 !== 1'b1 || mrv0 !== 32'h0) begin
      failures++;
      $display("FAIL store_after ready=%b we_n=%b mrv=%h want 1 1 0", ready0, we_n0, mrv0);
    end
  endtask

  task automatic test_load();
    r_en0 = 1'b1; alu0 = 32'd1032;
    #1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (ready0 !== (i == 5) || we_n0 !== 1'b1 || oe0 !== 1'b0) begin
        failures++;
        $display("FAIL load_ctl cyc=%0d ready=%b we_n=%b oe=%b want ready=%b we_n=1 oe=0", i, ready0, we_n0, oe0, i == 5);
      end
      if (i == 1 || i == 3) begin
        checks++;
        if (addr0 !== ((i == 1) ? 18'd4 : 18'd5)) begin
          failures++;
          $display("FAIL load_addr cyc=%0d got %0d want %0d", i, addr0, (i == 1) ? 4 : 5);
        end
      end
      if (i == 3) begin
        checks++;
        if (mrv0 !== 32'h0000BEEF) begin
          failures++;
          $display("FAIL load_low_half got %h want 0000beef", mrv0);
        end
      end
      if (i == 5) begin
        checks++;
        if (mrv0 !== 32'hDEADBEEF) begin
          failures++;
          $display("FAIL load_data got %h want deadbeef", mrv0);
        end
      end
    end
    tick();
    r_en0 = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    int unsigned we_low = 0;
    int unsigned ready_low = 0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) tick();
      if (i <= 5) begin
        w_en0 = 1'b1; r_en0 = 1'b0; alu0 = 32'd1036; val0 = 32'h12345678;
      end else if (i <= 11) begin
        w_en0 = 1'b0; r_en0 = 1'b1; alu0 = 32'd1036; val0 = 32'h0;
      end else begin
        w_en0 = 1'b0; r_en0 = 1'b0;
      end
      #1;
      if (!we_n0) we_low++;
      if (!ready0) ready_low++;
      if (i == 5) begin
        checks++;
        if (ready0 !== 1'b1 || mrv0 !== 32'hDEADBEEF) begin
          failures++;
          $display("FAIL b2b_store_done ready=%b mrv=%h want 1 deadbeef", ready0, mrv0);
        end
      end
      if (i == 11) begin
        checks++;
        if (ready0 !== 1'b1 || mrv0 !== 32'h12345678) begin
          failures++;
          $display("FAIL b2b_load_done ready=%b mrv=%h want 1 12345678", ready0, mrv0);
        end
      end
    end
    checks++;
    if (we_low != 4) begin
      failures++;
      $display("FAIL b2b_write_cycles got %0d want 4", we_low);
    end
    checks++;
    if (ready_low != 10) begin
      failures++;
      $display("FAIL b2b_stall_cycles got %0d want 10", ready_low);
    end
  endtask

  task automatic test_reset_mid_write();
    w_en0 = 1'b1; r_en0 = 1'b0; alu0 = 32'd1040; val0 = 32'hA5A55A5A;
    #1;
    for (int i = 1; i <= 4; i++) tick();
    checks++;
    if (addr0 !== 18'd9 || we_n0 !== 1'b0 || dq_out0 !== 16'hA5A5) begin
      failures++;
      $display("FAIL rstmid_pre addr=%0d we_n=%b dq=%h want 9 0 a5a5", addr0, we_n0, dq_out0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    w_en0 = 1'b0;
    #1;
    checks++;
    if (we_n0 !== 1'b1 || oe0 !== 1'b0 || ready0 !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ctl we_n=%b oe=%b ready=%b want 1 0 1", we_n0, oe0, ready0);
    end
    checks++;
    if (mrv0 !== 32'h0 || addr0 !== 18'h0 || dq_out0 !== 16'h0) begin
      failures++;
      $display("FAIL rstmid_data mrv=%h addr=%h dq=%h want 0", mrv0, addr0, dq_out0);
    end
    tick();
    checks++;
    if (ready0 !== 1'b1 || we_n0 !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_idle ready=%b we_n=%b want 1 1", ready0, we_n0);
    end
  endtask

  task automatic test_both_enables();
    w_en0 = 1'b1; r_en0 = 1'b1; alu0 = 32'd1024; val0 = 32'h0BADF00D;
    #1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) tick();
      if (i >= 1 && i <= 4) begin
        checks++;
        if (we_n0 !== 1'b0 || addr0 !== ((i <= 2) ? 18'd0 : 18'd1) ||
            dq_out0 !== ((i <= 2) ? 16'hF00D : 16'h0BAD)) begin
          failures++;
          $display("FAIL both_write cyc=%0d we_n=%b addr=%0d dq=%h", i, we_n0, addr0, dq_out0);
        end
      end
    end
    checks++;
    if (ready0 !== 1'b1 || mrv0 !== 32'h0) begin
      failures++;
      $display("FAIL both_done ready=%b mrv=%h want 1 00000000", ready0, mrv0);
    end
    tick();
    w_en0 = 1'b0; r_en0 = 1'b0;
    #1;
    checks++;
    if (sram_mem0[0] !== 16'hF00D || sram_mem0[1] !== 16'h0BAD) begin
      failures++;
      $display("FAIL both_sram mem0=%h mem1=%h want f00d 0bad", sram_mem0[0], sram_mem0[1]);
    end
  endtask

  task automatic test_wait1();
    w_en1 = 1'b1; r_en1 = 1'b1; alu1 = 32'd1028; val1 = 32'hCAFE1234;
    #1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (ready1 !== (i == 3)) begin
        failures++;
        $display("FAIL w1_store_ready cyc=%0d got %b want %b", i, ready1, i == 3);
      end
      if (i == 1 || i == 2) begin
        checks++;
        if (we_n1 !== 1'b0 || addr1 !== ((i == 1) ? 18'd2 : 18'd3) ||
            dq_out1 !== ((i == 1) ? 16'h1234 : 16'hCAFE)) begin
          failures++;
          $display("FAIL w1_store_bus cyc=%0d we_n=%b addr=%0d dq=%h", i, we_n1, addr1, dq_out1);
        end
      end
    end
    checks++;
    if (mrv1 !== 32'h0) begin
      failures++;
      $display("FAIL w1_store_mrv got %h want 00000000", mrv1);
    end
    tick();
    w_en1 = 1'b0; r_en1 = 1'b1;
    #1;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) tick();
      checks++;
      if (ready1 !== (i == 3) || we_n1 !== 1'b1) begin
        failures++;
        $display("FAIL w1_load_ctl cyc=%0d ready=%b we_n=%b want ready=%b we_n=1", i, ready1, we_n1, i == 3);
      end
    end
    checks++;
    if (mrv1 !== 32'hCAFE1234) begin
      failures++;
      $display("FAIL w1_load_data got %h want cafe1234", mrv1);
    end
    tick();
    r_en1 = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid_write();
    test_both_enables();
    test_wait1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
